pipeline_hazard_controller: RTL

- Central stall/flush/redirect sequencer for the 5-stage core (Fetch, Decode, Execute, MemoryAccess, WriteBack).
- Consumes hazard-relevant fields from the Decode, Execute and MemoryAccess stage pipe registers, plus data-memory readiness and WriteBack halt retirement.
- Drives per-stage stall and flush controls, the fetch redirect, and a halt drain state machine.
- Keeps saturating performance counters for stall and flush events.

---
 rtl/pipeline_hazard_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush/redirect sequencer for the 5-stage core, with a halt
// drain state machine and saturating stall/flush event counters.
module pipeline_hazard_controller #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      decodeValid,
  input  logic [REG_ADDR_WIDTH-1:0] decodeRs1,
  input  logic [REG_ADDR_WIDTH-1:0] decodeRs2,
  input  logic                      decodeUsesRs1,
  input  logic                      decodeUsesRs2,
  input  logic                      exValid,
  input  logic                      exIsLoad,
  input  logic                      exIsHalt,
  input  logic [REG_ADDR_WIDTH-1:0] exRd,
  input  logic                      exRdWriteEnable,
  input  logic                      maMispredict,
  input  logic [PC_WIDTH-1:0]       maRedirectPc,
  input  logic                      maMemReq,
  input  logic                      dmemReady,
  input  logic                      wbHaltRetired,
  output logic                      stallFetch,
  output logic                      stallDecode,
  output logic                      stallExecute,
  output logic                      stallMemory,
  output logic                      flushDecode,
  output logic                      flushExecute,
  output logic                      flushMemory,
  output logic                      flushWriteBack,
  output logic                      redirectValid,
  output logic [PC_WIDTH-1:0]       redirectPc,
  output logic                      halted,
  output logic [CNT_WIDTH-1:0]      loadUseCnt,
  output logic [CNT_WIDTH-1:0]      mispredictCnt,
  output logic [CNT_WIDTH-1:0]      memStallCnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrlState_t;

  ctrlState_t state;
  ctrlState_t stateNext;

  logic memStall;
  logic loadUse;
  logic loadUseEvt;
  logic mispredictEvt;
  logic memStallEvt;

  assign memStall = maMemReq & ~dmemReady;

  assign loadUse = exValid & exIsLoad & exRdWriteEnable & (exRd != '0) & decodeValid &
                   ((decodeUsesRs1 & (decodeRs1 == exRd)) |
                    (decodeUsesRs2 & (decodeRs2 == exRd)));

  // State register, registered halt flag and saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      halted        <= 1'b0;
      loadUseCnt    <= '0;
      mispredictCnt <= '0;
      memStallCnt   <= '0;
    end else begin
      state  <= stateNext;
      halted <= (stateNext == HALTED);
      if (loadUseEvt && (loadUseCnt != '1))
        loadUseCnt <= loadUseCnt + CNT_WIDTH'(1);
      if (mispredictEvt && (mispredictCnt != '1))
        mispredictCnt <= mispredictCnt + CNT_WIDTH'(1);
      if (memStallEvt && (memStallCnt != '1))
        memStallCnt <= memStallCnt + CNT_WIDTH'(1);
    end
  end

  // Priority-ordered hazard resolution and next-state selection
  always_comb begin
    stateNext      = state;
    stallFetch     = 1'b0;
    stallDecode    = 1'b0;
    stallExecute   = 1'b0;
    stallMemory    = 1'b0;
    flushDecode    = 1'b0;
    flushExecute   = 1'b0;
    flushMemory    = 1'b0;
    flushWriteBack = 1'b0;
    redirectValid  = 1'b0;
    redirectPc     = '0;
    loadUseEvt     = 1'b0;
    mispredictEvt  = 1'b0;
    memStallEvt    = 1'b0;

    if (state == HALTED) begin
      stallFetch     = 1'b1;
      stallDecode    = 1'b1;
      stallExecute   = 1'b1;
      stallMemory    = 1'b1;
      flushWriteBack = 1'b1;
    end else if (memStall) begin
      stallFetch     = 1'b1;
      stallDecode    = 1'b1;
      stallExecute   = 1'b1;
      stallMemory    = 1'b1;
      flushWriteBack = 1'b1;
      memStallEvt    = 1'b1;
    end else if (maMispredict) begin
      redirectValid = 1'b1;
      redirectPc    = maRedirectPc;
      flushDecode   = 1'b1;
      flushExecute  = 1'b1;
      flushMemory   = 1'b1;
      mispredictEvt = 1'b1;
    end else if (state == DRAIN) begin
      stallFetch   = 1'b1;
      stallDecode  = 1'b1;
      flushExecute = 1'b1;
    end else if (loadUse) begin
      stallFetch   = 1'b1;
      stallDecode  = 1'b1;
      flushExecute = 1'b1;
      loadUseEvt   = 1'b1;
    end

    unique case (state)
      RUN: begin
        if (exValid && exIsHalt && !maMispredict && !memStall)
          stateNext = DRAIN;
      end
      DRAIN: begin
        // A mispredict proves the draining halt was on the wrong path
        if (maMispredict && !memStall)
          stateNext = RUN;
        else if (wbHaltRetired)
          stateNext = HALTED;
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = RUN;
    endcase

    if (!rst) begin
      stallFetch     = 1'b0;
      stallDecode    = 1'b0;
      stallExecute   = 1'b0;
      stallMemory    = 1'b0;
      flushDecode    = 1'b0;
      flushExecute   = 1'b0;
      flushMemory    = 1'b0;
      flushWriteBack = 1'b0;
      redirectValid  = 1'b0;
      redirectPc     = '0;
    end
  end

endmodule
